// File: rtl/pito_loader_pkg.sv
// Shared types for the pito boot-time program loader.
// Build option LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to each frame.
package pito_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [7:0] LOADER_MAGIC_DEFAULT = 8'hA5;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/pito_prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader drives the slave side; the stream source and imem sit on the master side.
interface pito_prog_loader_if
    import pito_loader_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_W = 10
);

    logic [7:0]             s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic                   imem_we;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    word_t                  imem_wdata;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

endinterface

// File: rtl/pito_loader_word_pack.sv
// Packs little-endian payload bytes into 32-bit words; word_valid pulses the cycle
// after the fourth byte of a word. clear restarts packing at a new frame.
module pito_loader_word_pack
    import pito_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic [1:0] lane,
    output logic       word_valid,
    output word_t      word
);

    logic [23:0] partial;

    // Earlier bytes shift down so the first byte of a word ends up in bits [7:0].
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane       <= 2'd0;
            partial    <= 24'd0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (in_valid) begin
                lane <= lane + 2'd1;
                if (lane == 2'd3) begin
                    word       <= {in_data, partial};
                    word_valid <= 1'b1;
                end else begin
                    partial <= {in_data, partial[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/pito_prog_loader.sv
// Framed byte-stream loader: writes the image into imem and releases core reset on success.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module pito_prog_loader
    import pito_loader_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_W = 10,
    parameter int unsigned BASE_ADDR   = 0,
    parameter logic [7:0]  MAGIC       = LOADER_MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    pito_prog_loader_if.slave bus,
    input  logic              restart,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [IMEM_ADDR_W-1:0] BASE_W    = IMEM_ADDR_W'(BASE_ADDR);
    localparam logic [16:0]            MAX_WORDS = 17'(1 << IMEM_ADDR_W);

    loader_state_t state;
    logic [7:0]    len_lo;
    logic [15:0]   len;
    logic [15:0]   word_cnt;
    logic [16:0]   n_words;
    logic          beat;
    logic          frame_start;
    logic          last_word;
    logic [1:0]    lane;
    logic          word_valid;
    word_t         word;

    assign beat        = bus.s_valid & bus.s_ready;
    assign frame_start = beat && (state == IDLE) && (bus.s_data == MAGIC);
    assign n_words     = {1'b0, bus.s_data, len_lo};
    assign last_word   = (word_cnt == len - 16'd1);

    pito_loader_word_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clear      (frame_start),
        .in_valid   (beat && (state == DATA)),
        .in_data    (bus.s_data),
        .lane       (lane),
        .word_valid (word_valid),
        .word       (word)
    );

    assign bus.imem_we    = word_valid;
    assign bus.imem_wdata = word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR over the length bytes and the payload.
    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            csum <= 8'd0;
        end else if (beat && (state == LEN0 || state == LEN1 || state == DATA)) begin
            csum <= csum ^ bus.s_data;
        end
    end
`endif

    // Frame sequencing; s_ready, core_rst and the sticky flags change with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.s_ready   <= 1'b1;
            bus.imem_addr <= '0;
            core_rst      <= 1'b1;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
            len_lo        <= 8'd0;
            len           <= 16'd0;
            word_cnt      <= 16'd0;
        end else begin
            if (word_valid) begin
                bus.imem_addr <= bus.imem_addr + IMEM_ADDR_W'(1);
            end
            case (state)
                IDLE: if (frame_start) begin
                    state         <= LEN0;
                    bus.imem_addr <= BASE_W;
                    word_cnt      <= 16'd0;
                end
                LEN0: if (beat) begin
                    len_lo <= bus.s_data;
                    state  <= LEN1;
                end
                LEN1: if (beat) begin
                    len <= n_words[15:0];
                    if (n_words > MAX_WORDS) begin
                        state       <= ERR;
                        bus.s_ready <= 1'b0;
                        load_err    <= 1'b1;
                    end else if (n_words == 17'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= CSUM;
`else
                        state       <= DONE;
                        bus.s_ready <= 1'b0;
                        core_rst    <= 1'b0;
                        load_done   <= 1'b1;
`endif
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (beat && lane == 2'd3) begin
                    word_cnt <= word_cnt + 16'd1;
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= CSUM;
`else
                        state       <= DONE;
                        bus.s_ready <= 1'b0;
                        core_rst    <= 1'b0;
                        load_done   <= 1'b1;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: if (beat) begin
                    bus.s_ready <= 1'b0;
                    if (bus.s_data == csum) begin
                        state     <= DONE;
                        core_rst  <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        state    <= ERR;
                        load_err <= 1'b1;
                    end
                end
`endif
                DONE, ERR: if (restart) begin
                    state       <= IDLE;
                    bus.s_ready <= 1'b1;
                    core_rst    <= 1'b1;
                    load_done   <= 1'b0;
                    load_err    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
